// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, bit-timing helper
// and the frame delimiters used by the downstream decoder chain.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    localparam logic [7:0] DATA_FRAME_HEADER = 8'h40;
    localparam logic [7:0] DATA_FRAME_TAIL   = 8'hbc;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_cpb(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/m_uart_rx_sync.sv
// Line conditioning for the UART receiver: 2-FF synchronizer, 3-sample majority
// filter and falling-edge detector on the synchronized line.
module m_uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    output logic o_s_line,
    output logic o_s_bit,
    output logic o_s_fall
);

    logic       r_meta;
    logic       r_sync;
    logic [2:0] r_hist;

    // Everything resets to 1 so an idle line never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 3'b111;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_hist <= {r_hist[1:0], r_sync};
        end
    end

    assign o_s_line = r_sync;
    assign o_s_bit  = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
    // r_hist[0] is the synchronized line one cycle earlier.
    assign o_s_fall = r_hist[0] & ~r_sync;

endmodule

// File: rtl/m_uart_rx.sv
// UART receiver (8 data bits, optional parity, 1 stop bit) producing byte strobes
// plus framing/parity error pulses for the frame decoder.
module m_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_rx_en,
    output logic [7:0] o_rx_data,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);

    localparam int   CPB    = calc_cpb(CLK_HZ, BAUD);
    localparam int   CNT_W  = $clog2(CPB);
    localparam logic ODD    = (PARITY_ODD != 0);

    if (CPB < 8) begin : g_cpb_check
        $error("m_uart_rx: clocks per bit (%0d) must be at least 8", CPB);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

    logic w_s_line;
    logic w_s_bit;
    logic w_s_fall;
    logic w_sample;

    uart_state_t      r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par_bad;
    logic             r_rx_en;
    logic [7:0]       r_rx_data;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             r_busy;

    m_uart_rx_sync u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rxd    (i_rxd),
        .o_s_line (w_s_line),
        .o_s_bit  (w_s_bit),
        .o_s_fall (w_s_fall)
    );

    assign w_sample = (r_clk_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_rx_en      <= 1'b0;
            r_rx_data    <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_en      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s_fall) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    // Half a bit in: realign the counter so later samples land mid-bit.
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        if (w_s_bit) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_s_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_clk_cnt <= '0;
                        r_par_bad <= ((^r_shift) ^ w_s_bit) != ODD;
                        r_state   <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
                    if (w_sample) begin
                        r_clk_cnt <= '0;
                        if (w_s_bit) begin
                            if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_rx_en   <= 1'b1;
                                r_rx_data <= r_shift;
                            end
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_s_line) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rx_en      = r_rx_en;
    assign o_rx_data    = r_rx_data;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_m_uart_rx.sv
// Directed bench for m_uart_rx at 16 clocks per bit: 8N1 instance plus an
// odd-parity instance, with strobe monitors and hand-computed expectations.
module tb_m_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 16;

    logic       clk = 1'b0;
    logic       rst, rxd, rst_p, rxd_p;
    logic       rx_en, frame_err, par_err, busy;
    logic [7:0] rx_data;
    logic       rx_en_p, frame_err_p, par_err_p, busy_p;
    logic [7:0] rx_data_p;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int en_cnt = 0, frm_cnt = 0, par_cnt = 0, en_cyc = 0;
    int en_cnt_p = 0, frm_cnt_p = 0, par_cnt_p = 0;
    int excl_bad = 0, wide_bad = 0;
    logic prev_strobe = 1'b0, prev_strobe_p = 1'b0;
    logic [7:0] rx_log [0:63];

    bit gap_track = 1'b0;
    bit gap_arm = 1'b0;
    int gap = 0, max_gap = 0;

    int start_cyc = 0;

    m_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd),
        .o_rx_en(rx_en), .o_rx_data(rx_data), .o_frame_err(frame_err),
        .o_parity_err(par_err), .o_busy(busy)
    );

    m_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
        .i_clk(clk), .i_rst(rst_p), .i_rxd(rxd_p),
        .o_rx_en(rx_en_p), .o_rx_data(rx_data_p), .o_frame_err(frame_err_p),
        .o_parity_err(par_err_p), .o_busy(busy_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_en === 1'b1) begin
            if (en_cnt < 64) rx_log[en_cnt] <= rx_data;
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc;
        end
        if (frame_err === 1'b1) frm_cnt <= frm_cnt + 1;
        if (par_err === 1'b1) par_cnt <= par_cnt + 1;
        if (rx_en_p === 1'b1) en_cnt_p <= en_cnt_p + 1;
        if (frame_err_p === 1'b1) frm_cnt_p <= frm_cnt_p + 1;
        if (par_err_p === 1'b1) par_cnt_p <= par_cnt_p + 1;
        if ((int'(rx_en) + int'(frame_err) + int'(par_err) > 1) ||
            (int'(rx_en_p) + int'(frame_err_p) + int'(par_err_p) > 1))
            excl_bad <= excl_bad + 1;
        if (((rx_en | frame_err | par_err) & prev_strobe) ||
            ((rx_en_p | frame_err_p | par_err_p) & prev_strobe_p))
            wide_bad <= wide_bad + 1;
        prev_strobe   <= rx_en | frame_err | par_err;
        prev_strobe_p <= rx_en_p | frame_err_p | par_err_p;
        if (!gap_track) begin
            gap_arm <= 1'b0;
            max_gap <= 0;
            gap     <= 0;
        end else if (busy) begin
            if (gap_arm && gap > max_gap) max_gap <= gap;
            gap_arm <= 1'b1;
            gap     <= 0;
        end else begin
            gap <= gap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
        checks++;
        assert (val >= lo && val <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic val, input int n);
        if (sel) rxd_p = val;
        else rxd = val;
        idle(n);
    endtask

    // spike >= 0 puts a 1-clock high pulse 7 clocks into that data bit
    task automatic send_frame(input bit sel, input logic [7:0] b, input bit with_par,
                              input logic pbit, input logic stop, input int spike);
        start_cyc = cyc;
        drive_bit(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == spike) begin
                drive_bit(sel, b[i], 7);
                drive_bit(sel, ~b[i], 1);
                drive_bit(sel, b[i], 8);
            end else begin
                drive_bit(sel, b[i], CPB);
            end
        end
        if (with_par) drive_bit(sel, pbit, CPB);
        drive_bit(sel, stop, CPB);
    endtask

    logic [7:0] seq [0:6];
    int e0, f0, p0, bh;

    initial begin
        seq[0] = 8'h40; seq[1] = 8'h05; seq[2] = 8'h11; seq[3] = 8'h22;
        seq[4] = 8'h33; seq[5] = 8'h44; seq[6] = 8'hbc;
        rst = 1'b1; rst_p = 1'b1; rxd = 1'b1; rxd_p = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_en", rx_en, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_par_err", par_err_p, 0);
        idle(1);
        rst = 1'b0; rst_p = 1'b0;
        idle(20);

        // single 0x40 frame and its latency
        e0 = en_cnt; f0 = frm_cnt;
        send_frame(0, 8'h40, 0, 0, 1, -1);
        idle(20);
        chk("single_cnt", en_cnt - e0, 1);
        chk("single_data", rx_log[e0], 8'h40);
        chk_rng("single_latency", en_cyc - start_cyc, 153, 157);
        chk("single_no_ferr", frm_cnt - f0, 0);

        // back-to-back stream
        e0 = en_cnt;
        gap_track = 1'b1;
        for (int i = 0; i < 7; i++) send_frame(0, seq[i], 0, 0, 1, -1);
        idle(20);
        chk("b2b_cnt", en_cnt - e0, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("b2b_data%0d", i), rx_log[e0 + i], seq[i]);
        chk_rng("b2b_max_gap", max_gap, 0, 8);
        gap_track = 1'b0;
        idle(10);

        // 4-clock low glitch -> false start
        e0 = en_cnt; f0 = frm_cnt; bh = 0;
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bh++;
            @(posedge clk);
            #1;
            if (i == 3) rxd = 1'b1;
        end
        chk_rng("glitch_busy_len", bh, 8, 10);
        chk("glitch_no_strobe", en_cnt - e0, 0);
        chk("glitch_no_ferr", frm_cnt - f0, 0);

        // 1-clock high spike inside bit 3 of 0x00
        e0 = en_cnt;
        send_frame(0, 8'h00, 0, 0, 1, 3);
        idle(20);
        chk("spike_cnt", en_cnt - e0, 1);
        chk("spike_data", rx_log[e0], 8'h00);

        // framing error then break
        e0 = en_cnt; f0 = frm_cnt;
        send_frame(0, 8'ha5, 0, 0, 0, -1);
        idle(40);
        chk("ferr_cnt", frm_cnt - f0, 1);
        chk("ferr_no_strobe", en_cnt - e0, 0);
        chk("break_busy", busy, 1);
        rxd = 1'b1;
        idle(10);
        chk("break_exit", busy, 0);
        send_frame(0, 8'h3c, 0, 0, 1, -1);
        idle(20);
        chk("after_break_cnt", en_cnt - e0, 1);
        chk("after_break_data", rx_data, 8'h3c);

        // odd parity instance
        e0 = en_cnt_p; p0 = par_cnt_p;
        send_frame(1, 8'h03, 1, 1'b1, 1, -1);
        idle(20);
        chk("par_good_cnt", en_cnt_p - e0, 1);
        chk("par_good_data", rx_data_p, 8'h03);
        chk("par_good_noerr", par_cnt_p - p0, 0);
        send_frame(1, 8'h03, 1, 1'b0, 1, -1);
        idle(20);
        chk("par_bad_err", par_cnt_p - p0, 1);
        chk("par_bad_no_strobe", en_cnt_p - e0, 1);
        chk("par_bad_data_held", rx_data_p, 8'h03);
        chk("par_no_ferr", frm_cnt_p, 0);

        // async reset during bit 4 of 0x55
        e0 = en_cnt;
        drive_bit(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(0, (i % 2 == 0), CPB);
        drive_bit(0, 1'b1, 8);
        chk("pre_rst_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data", rx_data, 0);
        chk("async_rst_en", rx_en, 0);
        idle(3);
        rst = 1'b0;
        rxd = 1'b1;
        idle(40);
        chk("rst_no_strobe", en_cnt - e0, 0);
        send_frame(0, 8'h55, 0, 0, 1, -1);
        idle(20);
        chk("resend_cnt", en_cnt - e0, 1);
        chk("resend_data", rx_data, 8'h55);

        chk("strobe_exclusive", excl_bad, 0);
        chk("strobe_width", wide_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_uart_rx.md
Name: m_uart_rx

Overview:
- UART receiver that sits directly upstream of the frame decoder (m_decoder).
- Turns the asynchronous serial line into byte strobes: o_rx_en is a 1-cycle pulse with o_rx_data valid, which drives the decoder's i_rx_en/i_rx_data.
- Frame format is 8N1, with optional parity. The line is sampled at mid-bit with a 3-sample majority vote.
- Flags false starts, framing errors and parity errors.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- Derived constant CPB = (CLK_HZ + BAUD/2) / BAUD, clocks per bit. Elaboration error if CPB < 8.

Ports:
- i_clk  input  1  system clock, all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rxd  input  1  raw serial line, asynchronous, idle high.
- o_rx_en  output  1  1-cycle strobe: o_rx_data holds a good byte.
- o_rx_data  output  8  received byte, LSB first on the line; held until the next good byte.
- o_frame_err  output  1  1-cycle pulse: stop bit sampled low.
- o_parity_err  output  1  1-cycle pulse: parity mismatch.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; synchronizer and majority registers go to 1 (line idle).
  - Counters go to 0.
  - o_rx_en, o_frame_err, o_parity_err, o_busy and o_rx_data all go to 0.
  - Reset mid-frame abandons the byte with no strobe or error pulse.
- Input conditioning:
  - i_rxd passes through a 2-FF synchronizer, then a 3-bit history shift register.
  - s_bit = majority of the 3 history bits.
  - Edge detect uses the synchronized line directly: previous=1, current=0.
- Bit-period counter: clk_cnt runs 0..CPB-1 and bit_cnt runs 0..7. A "sample point" is clk_cnt==CPB-1 in DATA, PARITY and STOP.
- IDLE:
  - On a falling edge: clear clk_cnt and go to START.
- START:
  - At clk_cnt==CPB/2-1, evaluate s_bit.
  - s_bit=1 means a false start: return to IDLE with no flag.
  - s_bit=0: clear clk_cnt and go to DATA. From here every sample point is at mid-bit.
- DATA:
  - At each sample point, shift s_bit into bit 7 of the shift register (LSB first) and increment bit_cnt.
  - After the 8th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY:
  - At the sample point, par_bad = (^data ^ s_bit) != PARITY_ODD.
  - Store par_bad and go to STOP.
- STOP, at the sample point:
  - s_bit=1 and no parity error: the next cycle has o_rx_en=1 and o_rx_data=byte. Go to IDLE.
  - s_bit=1 with par_bad: the next cycle has o_parity_err=1, o_rx_en stays 0 and o_rx_data is unchanged. Go to IDLE.
  - s_bit=0: the next cycle has o_frame_err=1 with no strobe. Go to BREAK.
  - Returning to IDLE at mid-stop-bit tolerates up to ±5% baud mismatch and back-to-back frames.
- BREAK:
  - Stay until the synchronized line reads 1, then go to IDLE.
  - Prevents a held-low line (break) being decoded as a stream of 0x00 bytes.
- Latency: o_rx_en rises 1 cycle after the stop-bit sample point. That is about 9.5·CPB (10.5·CPB with parity) plus 3 cycles after the line's start edge.
- Strobe rules:
  - o_rx_en, o_frame_err and o_parity_err are mutually exclusive and never wider than 1 cycle.
  - At most one strobe per frame.
- A falling edge while not in IDLE is ignored (no re-synchronization mid-frame).

Decomposition:
- Package uart_pkg holds:
  - The state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5 (3-bit).
  - A function that computes CPB from CLK_HZ and BAUD.
  - The shared constants DATA_FRAME_HEADER=8'h40 and DATA_FRAME_TAIL=8'hbc, for benches that drive the decoder chain.
- One sub-module, m_uart_rx_sync: the 2-FF synchronizer, 3-bit majority filter and falling-edge detector, with outputs s_line, s_bit and s_fall.

Test Plan (all with CLK_HZ=1_600_000, BAUD=100_000, so CPB=16):
- Single frame 0x40, 8N1 -> exactly one o_rx_en pulse with o_rx_data=8'h40, 155±2 clocks after the start edge; no error pulses.
- Back-to-back bytes 40 05 11 22 33 44 bc, no idle gap, stop bits exactly 16 clocks -> 7 strobes in order with matching data; o_busy never stays low for more than 8 clocks between bytes.
- Low glitch of 4 clocks on the idle line -> false start, no strobe, no flags; o_busy is high for 8 to 10 clocks only. A 1-clock high spike mid data bit is masked by the majority vote, and the byte is received correctly.
- Frame 0xA5 with the stop bit driven low and the line held low for 40 clocks -> one o_frame_err pulse and no o_rx_en. The FSM stays in BREAK until the line goes high; the next valid 0x3C is received correctly.
- PARITY_EN=1, PARITY_ODD=1: 0x03 sent with parity bit 1 -> o_rx_en with 0x03. 0x03 sent with parity bit 0 -> o_parity_err pulse, no strobe, o_rx_data still 0x03 from the previous byte.
- Assert i_rst asynchronously during bit 4 of 0x55 -> all outputs go to 0 immediately; no strobe for the partial byte. After release, 0x55 resent -> received correctly.
